// File: rtl/display_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_mode_ctrl: sequences the 2-bit display select (clock/timer/        |
// | stopwatch), with inactivity fallback and alarm preemption.   Rev 1.0       |
// +----------------------------------------------------------------------------+
module display_mode_ctrl #(
  parameter int TIMEOUT_TICKS   = 10,
  parameter int FLASH_TICKS     = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       alarm,
  input  logic       sw_running,
  output logic [1:0] select,
  output logic       mode_changed,
  output logic       alarm_ack
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int FL_W = $clog2(FLASH_TICKS + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);
  localparam logic [FL_W-1:0] FL_LIMIT = FL_W'(FLASH_TICKS);
  localparam logic [DB_W-1:0] DB_LOAD  = DB_W'(DEBOUNCE_CYCLES);

  // State codes double as the select value for the three normal modes.
  localparam logic [1:0] ST_ALARM     = 2'b00;
  localparam logic [1:0] ST_TIMER     = 2'b01;
  localparam logic [1:0] ST_CLOCK     = 2'b10;
  localparam logic [1:0] ST_STOPWATCH = 2'b11;

  logic            sync1_q, sync2_q, btn_prev_q, alarm_prev_q;
  logic [DB_W-1:0] deb_q, deb_d;
  logic [1:0]      state_q, state_d, saved_q, saved_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [FL_W-1:0] fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic            mc_q, mc_d, ack_q, ack_d;
  logic            btn_edge, press, alarm_rise, to_active;

  always_comb begin
    btn_edge   = sync2_q & ~btn_prev_q;
    press      = btn_edge & (deb_q == '0);
    alarm_rise = alarm & ~alarm_prev_q;
    to_active  = (state_q == ST_TIMER) || ((state_q == ST_STOPWATCH) && !sw_running);

    state_d = state_q;
    saved_d = saved_q;
    to_d    = to_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    ack_d   = 1'b0;

    if (press) begin
      deb_d = DB_LOAD;
    end else if (deb_q != '0) begin
      deb_d = deb_q - DB_W'(1);
    end else begin
      deb_d = deb_q;
    end

    if (alarm_rise && (state_q != ST_ALARM)) begin
      // A coincident press is swallowed; the pre-press mode is what gets restored.
      saved_d = state_q;
      state_d = ST_ALARM;
      phase_d = 1'b0;
      fcnt_d  = '0;
    end else if (state_q == ST_ALARM) begin
      if (press) begin
        state_d = saved_q;
        ack_d   = 1'b1;
      end else if (!alarm) begin
        state_d = saved_q;
      end else if (tick) begin
        if (fcnt_q + FL_W'(1) == FL_LIMIT) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + FL_W'(1);
        end
      end
    end else if (press) begin
      case (state_q)
        ST_CLOCK: state_d = ST_TIMER;
        ST_TIMER: state_d = ST_STOPWATCH;
        default:  state_d = ST_CLOCK;
      endcase
    end else if (tick && to_active) begin
      if (to_q != TO_LIMIT) begin
        to_d = to_q + TO_W'(1);
      end
      if (to_d == TO_LIMIT) begin
        state_d = ST_CLOCK;
      end
    end

    if ((state_d != state_q) || press || (state_d == ST_CLOCK) || (state_d == ST_ALARM)) begin
      to_d = '0;
    end
    if (state_d != ST_ALARM) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end

    mc_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_prev_q   <= 1'b0;
      alarm_prev_q <= 1'b0;
      deb_q        <= '0;
      state_q      <= ST_CLOCK;
      saved_q      <= ST_CLOCK;
      to_q         <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      mc_q         <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      sync1_q      <= mode_btn;
      sync2_q      <= sync1_q;
      btn_prev_q   <= sync2_q;
      alarm_prev_q <= alarm;
      deb_q        <= deb_d;
      state_q      <= state_d;
      saved_q      <= saved_d;
      to_q         <= to_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      mc_q         <= mc_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    if (state_q == ST_ALARM) begin
      select = phase_q ? 2'b00 : 2'b01;
    end else begin
      select = state_q;
    end
  end

  assign mode_changed = mc_q;
  assign alarm_ack    = ack_q;

endmodule
`default_nettype wire
